add_sub_pipelined: RTL
======================

Name: add_sub_pipelined

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the IQ demod datapath. Intended uses: accumulators, correlator sums and phase differences.
- The SIZE-bit carry chain is split into STAGES equal chunks. Each chunk is a lookahead adder. The carry between chunks is registered, so timing closes at any SIZE.
- Adds a per-operation subtract mode, carry-out, signed overflow and optional saturation.
- Throughput is one operation per cycle.

Parameters:
- SIZE, 16, operand/result width in bits; must be ≥ 2.
- STAGES, 4, number of pipeline chunks; must be ≥ 1 and divide SIZE exactly. Chunk width W = SIZE/STAGES. Otherwise elaboration fails via $error.
- SATURATE, 0, 1 = clamp result to the signed range on overflow; 0 = two's-complement wrap.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- IN_VALID  in  1  A/B/SUB valid this cycle
- SUB  in  1  1 = A − B, 0 = A + B
- A  in  SIZE  operand A
- B  in  SIZE  operand B
- OUT_VALID  out  1  S/CARRY/OVERFLOW hold a new result
- S  out  SIZE  result
- CARRY  out  1  carry-out of MSB (for SUB: 1 = no borrow)
- OVERFLOW  out  1  signed overflow of the unsaturated result

Behaviour:
- Reset:
  - On RST high at a clock edge, OUT_VALID, S, CARRY, OVERFLOW, all stage valid bits and the inter-stage carries clear to 0.
  - Operations in flight are discarded and never produce OUT_VALID.
  - IN_VALID is ignored in any cycle where RST is high.
- Operand prep:
  - Effective B' = SUB ? ~B : B.
  - Carry-in to chunk 0 = SUB.
  - The SUB flag travels with its operation through the pipe.
- Stage k (0..STAGES−1):
  - Adds bits [k*W +: W] of A and B' with lookahead carry. Carry-in is the registered carry-out of stage k−1 (chunk 0 uses SUB).
  - Operand chunks for stage k are delayed k cycles (input skew). Lower result chunks are delayed so all chunks align at the output (output deskew).
- Latency:
  - IN_VALID high at edge n → OUT_VALID high for exactly one cycle after edge n+STAGES, with that operation's result.
  - STAGES=1 gives latency 1 (fully registered output).
- Throughput and ordering:
  - Back-to-back valid inputs give back-to-back results in order.
  - No backpressure: every accepted operation produces exactly one result.
- Idle and hold:
  - Gaps in IN_VALID propagate as OUT_VALID low.
  - Pipeline registers load only when their stage valid is set.
  - S, CARRY and OVERFLOW hold their last values while OUT_VALID is low.
- Flags:
  - CARRY = carry out of bit SIZE−1.
  - OVERFLOW = (carry into bit SIZE−1) XOR (carry out of bit SIZE−1).
- Saturation (SATURATE=1, OVERFLOW=1):
  - Raw S MSB = 1 (positive overflow) → S = 0x7F..F.
  - Raw S MSB = 0 (negative overflow) → S = 0x80..0.
  - CARRY and OVERFLOW report the unsaturated operation.
  - With SATURATE=0, S is the raw wrapped sum.
- Width rules: all arithmetic is modulo 2^SIZE; no sign extension inside the block.

Test Plan:
1. Config SIZE=16, STAGES=4, SATURATE=0. Hold RST high 2 cycles with IN_VALID=1 → OUT_VALID=0, S=0x0000, CARRY=0, OVERFLOW=0. OUT_VALID stays low through 4 cycles after RST deasserts, since no operation was accepted.
2. A=0x0FFF, B=0x0001, SUB=0 at edge n → at n+4: S=0x1000, CARRY=0, OVERFLOW=0. The carry ripples across three chunk boundaries. Then A=0xFFFF, B=0x0001 → S=0x0000, CARRY=1, OVERFLOW=0.
3. A=0x7FFF, B=0x0001 add → SATURATE=0: S=0x8000, OVERFLOW=1; SATURATE=1: S=0x7FFF, OVERFLOW=1. A=0x8000, B=0x0001 SUB → SATURATE=0: S=0x7FFF, OVERFLOW=1, CARRY=1; SATURATE=1: S=0x8000.
4. SUB: A=0x0003, B=0x0005 → S=0xFFFE, CARRY=0 (borrow), OVERFLOW=0. A=0x0005, B=0x0003 → S=0x0002, CARRY=1.
5. Stream: 8 consecutive random ops alternating SUB, a 2-cycle IN_VALID gap, then 4 more ops. Required: 12 results in order, each exactly 4 cycles after input, 2-cycle OUT_VALID gap, outputs held during the gap. Also check against the reference model for STAGES ∈ {1, 2, 16}.
6. Reset mid-flight: issue 3 ops on consecutive cycles, then assert RST for 1 cycle on the next edge → none of the 3 produce OUT_VALID. An op issued the cycle after RST deasserts returns correctly 4 cycles later.

Source files
------------

// File: rtl/add_sub_pipelined.sv
// Pipelined CLA add/sub with a registered carry between chunks; result appears STAGES cycles after IN_VALID.
// One op per cycle and no backpressure: every accepted op yields exactly one OUT_VALID pulse.
module add_sub_pipelined #(
  parameter int SIZE     = 16,
  parameter int STAGES   = 4,
  parameter int SATURATE = 0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_VALID,
  input  logic            SUB,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  output logic            OUT_VALID,
  output logic [SIZE-1:0] S,
  output logic            CARRY,
  output logic            OVERFLOW
);

  localparam int NS = (STAGES >= 1) ? STAGES : 1;
  localparam int W  = SIZE / NS;
  localparam int L  = NS - 1;

  if (SIZE < 2 || STAGES < 1 || (SIZE % NS) != 0) begin : g_param_check
    $error("add_sub_pipelined: SIZE must be >= 2 and an exact multiple of STAGES >= 1");
  end

  // Carries come from group generate/propagate terms, not from the previous carry.
  function automatic logic [W:0] cla(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin);
    logic [W-1:0] g, p, c;
    logic gg, pp;
    g  = a & b;
    p  = a ^ b;
    gg = 1'b0;
    pp = 1'b1;
    c  = '0;
    for (int i = 0; i < W; i++) begin
      c[i] = gg | (pp & cin);
      gg   = g[i] | (p[i] & gg);
      pp   = p[i] & pp;
    end
    return {gg | (pp & cin), p ^ c};
  endfunction

  logic [SIZE-1:0] w_b_eff;
  assign w_b_eff = SUB ? ~B : B;

  genvar k;
  for (k = 0; k < NS; k++) begin : g_stage
    localparam int RIN = SIZE - k * W;  // operand bits not yet consumed by earlier chunks

    logic               w_vld;
    logic               w_cin;
    logic [RIN-1:0]     w_a;
    logic [RIN-1:0]     w_b;
    logic [W:0]         w_sum;
    logic [(k+1)*W-1:0] w_s_nx;
    logic               r_vld;
    logic               r_c;
    logic [(k+1)*W-1:0] r_s;

    if (k == 0) begin : g_in
      assign w_vld  = IN_VALID;
      assign w_cin  = SUB;
      assign w_a    = A;
      assign w_b    = w_b_eff;
      assign w_s_nx = w_sum[W-1:0];
    end else begin : g_chain
      assign w_vld  = g_stage[k-1].r_vld;
      assign w_cin  = g_stage[k-1].r_c;
      assign w_a    = g_stage[k-1].g_fwd.r_a;
      assign w_b    = g_stage[k-1].g_fwd.r_b;
      assign w_s_nx = {w_sum[W-1:0], g_stage[k-1].r_s};
    end

    assign w_sum = cla(w_a[W-1:0], w_b[W-1:0], w_cin);

    always_ff @(posedge CLK) begin
      if (RST) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
      end else begin
        r_vld <= w_vld;
        if (w_vld) begin
          r_c <= w_sum[W];
          r_s <= w_s_nx;
        end
      end
    end

    if (k < NS - 1) begin : g_fwd
      logic [RIN-W-1:0] r_a;
      logic [RIN-W-1:0] r_b;
      always_ff @(posedge CLK) begin
        if (!RST && w_vld) begin
          r_a <= w_a[RIN-1:W];
          r_b <= w_b[RIN-1:W];
        end
      end
    end else begin : g_last
      logic r_ovf;
      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_ovf <= 1'b0;
        end else if (w_vld) begin
          r_ovf <= w_a[W-1] ^ w_b[W-1] ^ w_sum[W-1] ^ w_sum[W];
        end
      end
    end
  end

  logic [SIZE-1:0] w_raw;
  logic [SIZE-1:0] w_s_out;
  logic            w_ovf;

  assign w_raw = g_stage[L].r_s;
  assign w_ovf = g_stage[L].g_last.r_ovf;

  always_comb begin
    w_s_out = w_raw;
    if (SATURATE != 0 && w_ovf) begin
      w_s_out = w_raw[SIZE-1] ? {1'b0, {(SIZE-1){1'b1}}} : {1'b1, {(SIZE-1){1'b0}}};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      S         <= '0;
      CARRY     <= 1'b0;
      OVERFLOW  <= 1'b0;
    end else begin
      OUT_VALID <= g_stage[L].r_vld;
      if (g_stage[L].r_vld) begin
        S        <= w_s_out;
        CARRY    <= g_stage[L].r_c;
        OVERFLOW <= w_ovf;
      end
    end
  end

endmodule
